ddc_time_irq_sequencer: RTL
===========================

// Module: ddc_time_irq_sequencer
// PURPOSE
//  Avalon-MM master that services the DDC time-out PIO (26-bit input, edge-capture IRQ).
//  - At start-up: programs the PIO irq_mask register.
//  - On each irq: reads edge_capture, then data; clears edge_capture; pushes {capture,data} into an event FIFO.
//  - Sits between the PIO slave port and downstream event logging, so the HPS no longer services the PIO irq.
// PARAMETERS
//  IRQ_MASK    26'h3FFFFFF  value written to PIO irq_mask (addr 2) after reset
//  FIFO_DEPTH  8            event FIFO entries; power of 2, >= 2
//  OVF_W       16           width of saturating overflow counter
// PORTS
//  clk             in   1      system clock; all logic on posedge
//  reset           in   1      synchronous, active-high reset
//  enable          in   1      1 = service irqs; 0 = stop after current sequence
//  pio_irq         in   1      PIO irq output
//  avm_address     out  2      PIO register address
//  avm_chipselect  out  1      PIO chipselect
//  avm_write_n     out  1      PIO write strobe, active low
//  avm_writedata   out  32     PIO write data
//  avm_readdata    in   32     PIO readdata; registered in PIO, valid 1 cycle after address
//  ev_valid        out  1      event FIFO not empty
//  ev_ready        in   1      downstream accepts head entry when ev_valid & ev_ready
//  ev_data         out  EV_W   {capture[25:0], data[25:0]} (+ timestamp, see CONFIGURATION)
//  overflow_cnt    out  OVF_W  events dropped because FIFO was full; saturates at all-ones
//  busy            out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset (sync, high)
//   - state=INIT; FIFO emptied; overflow_cnt=0.
//   - Outputs: avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, ev_valid=0, busy=1.
//   - Reset mid-sequence aborts it; no push, no partial clear.
//  FSM, one cycle per state unless noted:
//   INIT    cs=1, write_n=0, addr=2, wdata={6'b0,IRQ_MASK} -> IDLE
//   IDLE    all bus outputs idle; if enable & pio_irq -> RD_CAP, else stay
//   RD_CAP  cs=1, write_n=1, addr=3 -> RD_DAT
//   RD_DAT  latch cap_r<=avm_readdata[25:0]; drive addr=0 -> SMP_DAT
//   SMP_DAT latch dat_r<=avm_readdata[25:0]; if cap_r==0 (spurious) -> IDLE, else -> CLR
//   CLR     cs=1, write_n=0, addr=3, wdata=0 (clears all capture bits) -> PUSH
//   PUSH    bus idle; push {cap_r,dat_r} if FIFO not full, else overflow_cnt++ (sat) -> IDLE
//  Timing
//   - PUSH doubles as settle cycle: pio_irq has already dropped after the CLR edge, so IDLE never re-triggers on a stale irq.
//   - irq -> entry visible on ev_valid: 6 cycles (IDLE detect + 5 states).
//  Boundaries
//   - An edge arriving in the RD_CAP..CLR window is cleared and lost; documented limitation, not counted.
//   - FIFO full at PUSH: drop new event; FIFO contents unchanged.
//   - Pop and push in the same cycle while full: pop first, push accepted, no overflow.
//   - FIFO is first-word fall-through: ev_data is valid whenever ev_valid=1; pop only on ev_valid & ev_ready.
//   - enable=0 mid-sequence: current sequence completes; then remain in IDLE.
//   - overflow_cnt holds at 2^OVF_W-1.
// CONFIGURATION
//  DDC_SEQ_TIMESTAMP_EN defined
//   - 32-bit free-running cycle counter; reset 0; wraps.
//   - Sampled on IDLE->RD_CAP transition; appended as ev_data MSBs.
//   - EV_W=84: {ts[31:0], cap[25:0], dat[25:0]}.
//  Not defined: no counter, EV_W=52.
// STRUCTURE
//  Package ddc_seq_pkg:
//   - state enum; PIO register address constants (DATA=0, MASK=2, EDGE=3)
//   - DDC_W=26; EV_W computed under the macro
//  Sub-module ddc_seq_fifo: FWFT sync FIFO, params DEPTH and WIDTH; ptrs with extra wrap bit; full/empty flags.
// TESTING (bench models PIO register behaviour, incl. 1-cycle readdata)
//  1. Reset release -> single write addr=2, wdata=32'h03FFFFFF one cycle later; then busy=0.
//  2. Rising edge on in_port[5], data=26'h0000020 -> reads addr 3 then 0, write addr 3; ev_data={26'h20,26'h20}, 6 cycles after irq.
//  3. ev_ready=0, 9 events, FIFO_DEPTH=8 -> ev_valid=1, overflow_cnt=1; drain yields the first 8 in order.
//  4. Irq forced with capture reading 0 -> no clear write, no push, back to IDLE.
//  5. enable=0 during RD_DAT -> sequence completes and pushes; later irqs are ignored until enable=1.
//  6. DDC_SEQ_TIMESTAMP_EN: irq detected in IDLE at counter=100 -> ev_data[83:52]=100; reset asserted in CLR -> FIFO empty, state INIT.

Source files
------------

// File: rtl/ddc_seq_pkg.sv
// Shared types and constants for the DDC time-out PIO irq sequencer.
// DDC_SEQ_TIMESTAMP_EN widens each event with a 32-bit cycle timestamp.
package ddc_seq_pkg;

  localparam int DDC_W = 26;

`ifdef DDC_SEQ_TIMESTAMP_EN
  localparam int TS_W = 32;
  localparam int EV_W = TS_W + 2 * DDC_W;
`else
  localparam int EV_W = 2 * DDC_W;
`endif

  // PIO register map
  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_CAP,
    ST_RD_DAT,
    ST_SMP_DAT,
    ST_CLR,
    ST_PUSH
  } state_e;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  localparam bus_cmd_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 2'd0, wdata: 32'd0};

  function automatic bus_cmd_t bus_cmd(input logic cs, input logic write_n,
                                       input logic [1:0] addr, input logic [31:0] wdata);
    bus_cmd_t c;
    c.cs      = cs;
    c.write_n = write_n;
    c.addr    = addr;
    c.wdata   = wdata;
    return c;
  endfunction

endpackage

// File: rtl/ddc_time_irq_sequencer_if.sv
// Avalon-MM bus between the sequencer (master) and the time-out PIO (slave).
interface ddc_time_irq_sequencer_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/ddc_seq_fifo.sv
// First-word fall-through sync FIFO; pointers carry an extra wrap bit so
// full/empty come straight from a compare.
module ddc_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 52
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop in the same cycle frees the slot the push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ddc_time_irq_sequencer.sv
// Services the DDC time-out PIO edge-capture irq and queues {capture,data} events.
// Optional DDC_SEQ_TIMESTAMP_EN prepends a free-running cycle stamp to each event.
module ddc_time_irq_sequencer
  import ddc_seq_pkg::*;
#(
  parameter logic [25:0] IRQ_MASK   = 26'h3FFFFFF,
  parameter int          FIFO_DEPTH = 8,
  parameter int          OVF_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            pio_irq,
  ddc_time_irq_sequencer_if.master        avm,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic [EV_W-1:0]                 ev_data,
  output logic [OVF_W-1:0]                overflow_cnt,
  output logic                            busy
);

  state_e           state;
  state_e           state_nxt;
  bus_cmd_t         cmd;
  bus_cmd_t         bus_q;
  logic [DDC_W-1:0] cap_r;
  logic [DDC_W-1:0] dat_r;
  logic             push;
  logic             full;
  logic             empty;
  logic             ovf_hit;
  logic             start_seq;
  logic [EV_W-1:0]  push_data;
  logic             unused_rd;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd       = BUS_IDLE;
    case (state)
      ST_INIT: begin
        cmd       = bus_cmd(1'b1, 1'b0, PIO_MASK, {6'b0, IRQ_MASK});
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (enable && pio_irq) state_nxt = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        cmd       = bus_cmd(1'b1, 1'b1, PIO_EDGE, 32'd0);
        state_nxt = ST_RD_DAT;
      end
      ST_RD_DAT: begin
        cmd       = bus_cmd(1'b1, 1'b1, PIO_DATA, 32'd0);
        state_nxt = ST_SMP_DAT;
      end
      ST_SMP_DAT: begin
        // An irq with nothing captured is spurious: skip the clear and the push.
        state_nxt = (cap_r == '0) ? ST_IDLE : ST_CLR;
      end
      ST_CLR: begin
        cmd       = bus_cmd(1'b1, 1'b0, PIO_EDGE, 32'd0);
        state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Bus is held idle while reset is high even though the state reads INIT.
  assign bus_q              = reset ? BUS_IDLE : cmd;
  assign avm.avm_chipselect = bus_q.cs;
  assign avm.avm_write_n    = bus_q.write_n;
  assign avm.avm_address    = bus_q.addr;
  assign avm.avm_writedata  = bus_q.wdata;

  assign unused_rd = ^avm.avm_readdata[31:DDC_W];

  // PIO readdata lags the address by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_r <= '0;
      dat_r <= '0;
    end else begin
      if (state == ST_RD_DAT)  cap_r <= avm.avm_readdata[DDC_W-1:0];
      if (state == ST_SMP_DAT) dat_r <= avm.avm_readdata[DDC_W-1:0];
    end
  end

  assign start_seq = (state == ST_IDLE) && (state_nxt == ST_RD_CAP);

`ifdef DDC_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
      ts_r   <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (start_seq) ts_r <= ts_cnt;
    end
  end

  assign push_data = {ts_r, cap_r, dat_r};
`else
  logic unused_start;
  assign unused_start = start_seq;
  assign push_data    = {cap_r, dat_r};
`endif

  assign push    = (state == ST_PUSH);
  assign ovf_hit = push & full & ~ev_ready;

  ddc_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_data),
    .pop   (ev_ready),
    .rdata (ev_data),
    .full  (full),
    .empty (empty)
  );

  assign ev_valid = ~empty;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset)
      overflow_cnt <= '0;
    else if (ovf_hit && (overflow_cnt != '1))
      overflow_cnt <= overflow_cnt + OVF_W'(1);
  end

endmodule
